// File: rtl/nv_nvdla_mcif_cdp_rdrsp_if.sv
// Handshake and backing-store signals between CDP and the MCIF read-response block.
// The slave modport is the block itself; master is the CDP/memory side.
interface nv_nvdla_mcif_cdp_rdrsp_if;
    logic        cdp2mcif_rd_req_valid;
    logic        cdp2mcif_rd_req_ready;
    logic [46:0] cdp2mcif_rd_req_pd;
    logic        mcif2cdp_rd_rsp_valid;
    logic        mcif2cdp_rd_rsp_ready;
    logic [64:0] mcif2cdp_rd_rsp_pd;
    logic        cdp2mcif_rd_cdt_lat_fifo_pop;
    logic        mem_rd_en;
    logic [31:0] mem_rd_addr;
    logic [63:0] mem_rd_data;

    modport slave (
        input  cdp2mcif_rd_req_valid, cdp2mcif_rd_req_pd, mcif2cdp_rd_rsp_ready,
               cdp2mcif_rd_cdt_lat_fifo_pop, mem_rd_data,
        output cdp2mcif_rd_req_ready, mcif2cdp_rd_rsp_valid, mcif2cdp_rd_rsp_pd,
               mem_rd_en, mem_rd_addr
    );

    modport master (
        output cdp2mcif_rd_req_valid, cdp2mcif_rd_req_pd, mcif2cdp_rd_rsp_ready,
               cdp2mcif_rd_cdt_lat_fifo_pop, mem_rd_data,
        input  cdp2mcif_rd_req_ready, mcif2cdp_rd_rsp_valid, mcif2cdp_rd_rsp_pd,
               mem_rd_en, mem_rd_addr
    );
endinterface

// File: rtl/nv_nvdla_mcif_cdp_rdrsp.sv
// CDP read path: splits a request into 8-byte atom reads gated by latency-FIFO
// credits and a 2-entry in-order response buffer.
module nv_nvdla_mcif_cdp_rdrsp #(
    parameter int LAT_DEPTH = 32
) (
    input logic                            nvdla_core_clk,
    input logic                            nvdla_core_rstn,
    nv_nvdla_mcif_cdp_rdrsp_if.slave       bus
);
    localparam logic [7:0] CDT_MAX = 8'(LAT_DEPTH);

    typedef enum logic {IDLE, BURST} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] remain_q, remain_d;
    logic [7:0]  credit_q, credit_d;
    logic        cdt_err_q, cdt_err_d;
    logic        inflight_q;
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, rd_ptr_q;
    logic [63:0] buf_q [2];

    logic        req_fire, issue, rsp_pop, cdt_pop;
    logic [1:0]  eff_occ;

    assign cdt_pop  = bus.cdp2mcif_rd_cdt_lat_fifo_pop;
    assign req_fire = bus.cdp2mcif_rd_req_valid && (state_q == IDLE);
    assign rsp_pop  = (count_q != 2'd0) && bus.mcif2cdp_rd_rsp_ready;

    // Occupancy net of this cycle's pop, so a drained entry frees its slot at once
    // and a steady stream reaches one atom per cycle.
    assign eff_occ = count_q - {1'b0, rsp_pop} + {1'b0, inflight_q};
    assign issue   = (state_q == BURST) && (credit_q != 8'd0) && (eff_occ < 2'd2);

    assign bus.cdp2mcif_rd_req_ready = (state_q == IDLE);
    assign bus.mem_rd_en             = issue;
    assign bus.mem_rd_addr           = addr_q;
    assign bus.mcif2cdp_rd_rsp_valid = (count_q != 2'd0);
    assign bus.mcif2cdp_rd_rsp_pd    = (count_q != 2'd0) ? {1'b1, buf_q[rd_ptr_q]} : 65'd0;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    addr_d   = bus.cdp2mcif_rd_req_pd[31:0] & ~32'h7;
                    remain_d = {1'b0, bus.cdp2mcif_rd_req_pd[46:32]} + 16'd1;
                    state_d  = BURST;
                end
            end
            BURST: begin
                if (issue) begin
                    addr_d   = addr_q + 32'd8;
                    remain_d = remain_q - 16'd1;
                    if (remain_q == 16'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        credit_d  = credit_q;
        cdt_err_d = cdt_err_q;
        if (issue && !cdt_pop) begin
            credit_d = credit_q - 8'd1;
        end else if (!issue && cdt_pop) begin
            // A return with the pool already full is a protocol error; saturate and flag it.
            if (credit_q == CDT_MAX) cdt_err_d = 1'b1;
            else                     credit_d  = credit_q + 8'd1;
        end
    end

    always_comb begin
        count_d = count_q;
        if (inflight_q && !rsp_pop)      count_d = count_q + 2'd1;
        else if (!inflight_q && rsp_pop) count_d = count_q - 2'd1;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q    <= IDLE;
            addr_q     <= 32'd0;
            remain_q   <= 16'd0;
            credit_q   <= CDT_MAX;
            cdt_err_q  <= 1'b0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            credit_q   <= credit_d;
            cdt_err_q  <= cdt_err_d;
            inflight_q <= issue;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_q ^ inflight_q;
            rd_ptr_q   <= rd_ptr_q ^ rsp_pop;
        end
    end

    // Read data lands one cycle after the strobe, i.e. while inflight_q is set.
    always_ff @(posedge nvdla_core_clk) begin
        if (inflight_q) buf_q[wr_ptr_q] <= bus.mem_rd_data;
    end
endmodule

// File: tb/tb_nv_nvdla_mcif_cdp_rdrsp.sv
// Directed bench for the CDP read-response block, built with a 4-credit pool.
module tb_nv_nvdla_mcif_cdp_rdrsp;
    logic clk;
    logic rstn;
    int   checks;
    int   failures;
    int   cyc;
    logic auto_pop;
    logic man_pop;
    logic fired_last;

    logic [31:0] iss_q[$];
    int          iss_cyc[$];
    logic [64:0] rsp_q[$];
    int          rsp_cyc[$];

    nv_nvdla_mcif_cdp_rdrsp_if bus();

    nv_nvdla_mcif_cdp_rdrsp #(.LAT_DEPTH(4)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.cdp2mcif_rd_cdt_lat_fifo_pop = auto_pop ? fired_last : man_pop;

    // Backing store returns {~addr, addr} one cycle after the strobe.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= {~bus.mem_rd_addr, bus.mem_rd_addr};
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        fired_last <= bus.mcif2cdp_rd_rsp_valid && bus.mcif2cdp_rd_rsp_ready;
        if (bus.mem_rd_en) begin
            iss_q.push_back(bus.mem_rd_addr);
            iss_cyc.push_back(cyc);
        end
        if (bus.mcif2cdp_rd_rsp_valid && bus.mcif2cdp_rd_rsp_ready) begin
            rsp_q.push_back(bus.mcif2cdp_rd_rsp_pd);
            rsp_cyc.push_back(cyc);
        end
    end

    function automatic logic [64:0] exp_pd(input logic [31:0] a);
        return {1'b1, ~a, a};
    endfunction

    task automatic clear_logs();
        iss_q.delete(); iss_cyc.delete(); rsp_q.delete(); rsp_cyc.delete();
    endtask

    task automatic send_req(input logic [31:0] addr, input logic [14:0] size);
        @(negedge clk);
        bus.cdp2mcif_rd_req_valid = 1'b1;
        bus.cdp2mcif_rd_req_pd    = {size, addr};
        @(negedge clk);
        bus.cdp2mcif_rd_req_valid = 1'b0;
        bus.cdp2mcif_rd_req_pd    = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks += 6;
        if (bus.cdp2mcif_rd_req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got %b want 1", bus.cdp2mcif_rd_req_ready); end
        if (bus.mcif2cdp_rd_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %b want 0", bus.mcif2cdp_rd_rsp_valid); end
        if (bus.mem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_mem_rd_en got %b want 0", bus.mem_rd_en); end
        if (bus.mem_rd_addr !== 32'd0) begin failures++; $display("FAIL reset_mem_rd_addr got %h want 0", bus.mem_rd_addr); end
        if (bus.mcif2cdp_rd_rsp_pd !== 65'd0) begin failures++; $display("FAIL reset_rsp_pd got %h want 0", bus.mcif2cdp_rd_rsp_pd); end
        if (dut.credit_q !== 8'd4) begin failures++; $display("FAIL reset_credit got %0d want 4", dut.credit_q); end
    endtask

    task automatic test_single_burst();
        auto_pop = 1'b1; bus.mcif2cdp_rd_rsp_ready = 1'b1; clear_logs();
        send_req(32'h0000_1000, 15'd3);
        checks++;
        if (bus.cdp2mcif_rd_req_ready !== 1'b0) begin failures++; $display("FAIL burst_req_ready got %b want 0", bus.cdp2mcif_rd_req_ready); end
        for (int i = 0; i < 40 && rsp_q.size() < 4; i++) @(negedge clk);
        checks++;
        if (rsp_q.size() != 4 || iss_q.size() != 4) begin
            failures++; $display("FAIL single_counts got iss=%0d rsp=%0d want 4/4", iss_q.size(), rsp_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks += 3;
                if (iss_q[i] !== 32'h1000 + 32'(8 * i)) begin failures++; $display("FAIL single_addr[%0d] got %h want %h", i, iss_q[i], 32'h1000 + 32'(8 * i)); end
                if (iss_cyc[i] != iss_cyc[0] + i) begin failures++; $display("FAIL single_consecutive[%0d] got cyc %0d want %0d", i, iss_cyc[i], iss_cyc[0] + i); end
                if (rsp_q[i] !== exp_pd(32'h1000 + 32'(8 * i))) begin failures++; $display("FAIL single_data[%0d] got %h want %h", i, rsp_q[i], exp_pd(32'h1000 + 32'(8 * i))); end
            end
            checks++;
            if (rsp_cyc[0] - iss_cyc[0] != 2) begin failures++; $display("FAIL single_latency got %0d want 2", rsp_cyc[0] - iss_cyc[0]); end
        end
        repeat (4) @(negedge clk);
        checks += 2;
        if (dut.credit_q !== 8'd4) begin failures++; $display("FAIL single_credit_back got %0d want 4", dut.credit_q); end
        if (bus.cdp2mcif_rd_req_ready !== 1'b1) begin failures++; $display("FAIL single_idle got %b want 1", bus.cdp2mcif_rd_req_ready); end
    endtask

    task automatic test_credit_exhaust();
        auto_pop = 1'b0; man_pop = 1'b0; bus.mcif2cdp_rd_rsp_ready = 1'b1; clear_logs();
        send_req(32'h0000_2000, 15'd7);
        repeat (20) @(negedge clk);
        checks += 3;
        if (iss_q.size() != 4) begin failures++; $display("FAIL credit_stall_issued got %0d want 4", iss_q.size()); end
        if (dut.credit_q !== 8'd0) begin failures++; $display("FAIL credit_zero got %0d want 0", dut.credit_q); end
        if (bus.cdp2mcif_rd_req_ready !== 1'b0) begin failures++; $display("FAIL credit_stall_ready got %b want 0", bus.cdp2mcif_rd_req_ready); end
        man_pop = 1'b1;
        @(negedge clk);
        man_pop = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (iss_q.size() != 5) begin failures++; $display("FAIL credit_one_pop got %0d want 5", iss_q.size()); end
        man_pop = 1'b1;
        repeat (7) @(negedge clk);
        man_pop = 1'b0;
        repeat (10) @(negedge clk);
        checks += 5;
        if (iss_q.size() != 8) begin failures++; $display("FAIL credit_total_issued got %0d want 8", iss_q.size()); end
        if (rsp_q.size() != 8) begin failures++; $display("FAIL credit_total_rsp got %0d want 8", rsp_q.size()); end
        if (dut.credit_q !== 8'd4) begin failures++; $display("FAIL credit_restored got %0d want 4", dut.credit_q); end
        if (bus.cdp2mcif_rd_req_ready !== 1'b1) begin failures++; $display("FAIL credit_idle got %b want 1", bus.cdp2mcif_rd_req_ready); end
        if (dut.cdt_err_q !== 1'b0) begin failures++; $display("FAIL credit_no_err got %b want 0", dut.cdt_err_q); end
        for (int i = 0; i < 8 && i < rsp_q.size(); i++) begin
            checks++;
            if (rsp_q[i] !== exp_pd(32'h2000 + 32'(8 * i))) begin failures++; $display("FAIL credit_data[%0d] got %h want %h", i, rsp_q[i], exp_pd(32'h2000 + 32'(8 * i))); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pattern;
        logic        prev_v, prev_r;
        logic [64:0] prev_pd;
        pattern = 32'b1011_0010_0110_1100_1001_0101_0011_0001;
        auto_pop = 1'b1; bus.mcif2cdp_rd_rsp_ready = 1'b0; clear_logs();
        prev_v = 1'b0; prev_r = 1'b0; prev_pd = '0;
        send_req(32'h0000_3004, 15'd5);
        for (int i = 0; i < 200 && rsp_q.size() < 6; i++) begin
            if (prev_v && !prev_r) begin
                checks++;
                if (bus.mcif2cdp_rd_rsp_valid !== 1'b1 || bus.mcif2cdp_rd_rsp_pd !== prev_pd) begin
                    failures++; $display("FAIL bp_hold got v=%b pd=%h want v=1 pd=%h", bus.mcif2cdp_rd_rsp_valid, bus.mcif2cdp_rd_rsp_pd, prev_pd);
                end
            end
            checks++;
            if (32'(dut.count_q) + 32'(dut.inflight_q) > 2) begin failures++; $display("FAIL bp_outstanding got %0d want <=2", 32'(dut.count_q) + 32'(dut.inflight_q)); end
            prev_v  = bus.mcif2cdp_rd_rsp_valid;
            prev_pd = bus.mcif2cdp_rd_rsp_pd;
            bus.mcif2cdp_rd_rsp_ready = pattern[i % 32];
            prev_r  = bus.mcif2cdp_rd_rsp_ready;
            @(negedge clk);
        end
        checks++;
        if (rsp_q.size() != 6) begin failures++; $display("FAIL bp_count got %0d want 6", rsp_q.size()); end
        for (int i = 0; i < 6 && i < rsp_q.size(); i++) begin
            checks++;
            if (rsp_q[i] !== exp_pd(32'h3000 + 32'(8 * i))) begin failures++; $display("FAIL bp_data[%0d] got %h want %h", i, rsp_q[i], exp_pd(32'h3000 + 32'(8 * i))); end
        end
        bus.mcif2cdp_rd_rsp_ready = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_addr_wrap();
        auto_pop = 1'b1; bus.mcif2cdp_rd_rsp_ready = 1'b1; clear_logs();
        send_req(32'hFFFF_FFF8, 15'd1);
        for (int i = 0; i < 30 && rsp_q.size() < 2; i++) @(negedge clk);
        checks++;
        if (iss_q.size() != 2 || rsp_q.size() != 2) begin
            failures++; $display("FAIL wrap_counts got iss=%0d rsp=%0d want 2/2", iss_q.size(), rsp_q.size());
        end else begin
            checks += 3;
            if (iss_q[0] !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_addr0 got %h want fffffff8", iss_q[0]); end
            if (iss_q[1] !== 32'h0000_0000) begin failures++; $display("FAIL wrap_addr1 got %h want 00000000", iss_q[1]); end
            if (rsp_q[1] !== exp_pd(32'h0)) begin failures++; $display("FAIL wrap_data1 got %h want %h", rsp_q[1], exp_pd(32'h0)); end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_simul_pop();
        auto_pop = 1'b0; man_pop = 1'b0; bus.mcif2cdp_rd_rsp_ready = 1'b1; clear_logs();
        send_req(32'h0000_4000, 15'd1);
        checks += 2;
        if (bus.mem_rd_en !== 1'b1) begin failures++; $display("FAIL simul_first_issue got %b want 1", bus.mem_rd_en); end
        if (dut.credit_q !== 8'd4) begin failures++; $display("FAIL simul_credit_pre got %0d want 4", dut.credit_q); end
        @(negedge clk);
        checks += 2;
        if (bus.mem_rd_en !== 1'b1) begin failures++; $display("FAIL simul_second_issue got %b want 1", bus.mem_rd_en); end
        if (dut.credit_q !== 8'd3) begin failures++; $display("FAIL simul_credit_dec got %0d want 3", dut.credit_q); end
        man_pop = 1'b1;
        @(negedge clk);
        checks++;
        if (dut.credit_q !== 8'd3) begin failures++; $display("FAIL simul_credit_same got %0d want 3", dut.credit_q); end
        @(negedge clk);
        checks += 2;
        if (dut.credit_q !== 8'd4) begin failures++; $display("FAIL simul_credit_full got %0d want 4", dut.credit_q); end
        if (dut.cdt_err_q !== 1'b0) begin failures++; $display("FAIL simul_err_early got %b want 0", dut.cdt_err_q); end
        @(negedge clk);
        man_pop = 1'b0;
        checks += 3;
        if (dut.credit_q !== 8'd4) begin failures++; $display("FAIL overpop_credit got %0d want 4", dut.credit_q); end
        if (dut.cdt_err_q !== 1'b1) begin failures++; $display("FAIL overpop_err got %b want 1", dut.cdt_err_q); end
        if (rsp_q.size() != 2) begin failures++; $display("FAIL simul_rsp_count got %0d want 2", rsp_q.size()); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        auto_pop = 1'b0; man_pop = 1'b0; bus.mcif2cdp_rd_rsp_ready = 1'b0; clear_logs();
        send_req(32'h0000_5000, 15'd7);
        for (int i = 0; i < 20 && iss_q.size() < 2; i++) @(negedge clk);
        checks++;
        if (iss_q.size() != 2) begin failures++; $display("FAIL rstmid_issued got %0d want 2", iss_q.size()); end
        rstn = 1'b0;
        #1;
        checks += 3;
        if (bus.cdp2mcif_rd_req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_req_ready got %b want 1", bus.cdp2mcif_rd_req_ready); end
        if (bus.mem_rd_addr !== 32'd0) begin failures++; $display("FAIL rstmid_addr got %h want 0", bus.mem_rd_addr); end
        if (bus.mcif2cdp_rd_rsp_pd !== 65'd0) begin failures++; $display("FAIL rstmid_pd got %h want 0", bus.mcif2cdp_rd_rsp_pd); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        bus.mcif2cdp_rd_rsp_ready = 1'b1;
        repeat (20) @(negedge clk);
        checks += 6;
        if (bus.cdp2mcif_rd_req_ready !== 1'b1) begin failures++; $display("FAIL rstpost_req_ready got %b want 1", bus.cdp2mcif_rd_req_ready); end
        if (bus.mcif2cdp_rd_rsp_valid !== 1'b0) begin failures++; $display("FAIL rstpost_rsp_valid got %b want 0", bus.mcif2cdp_rd_rsp_valid); end
        if (dut.credit_q !== 8'd4) begin failures++; $display("FAIL rstpost_credit got %0d want 4", dut.credit_q); end
        if (dut.cdt_err_q !== 1'b0) begin failures++; $display("FAIL rstpost_err got %b want 0", dut.cdt_err_q); end
        if (rsp_q.size() != 0) begin failures++; $display("FAIL rstpost_stale_rsp got %0d want 0", rsp_q.size()); end
        if (iss_q.size() != 2) begin failures++; $display("FAIL rstpost_issue got %0d want 2", iss_q.size()); end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        auto_pop = 1'b0; man_pop = 1'b0; fired_last = 1'b0;
        bus.cdp2mcif_rd_req_valid = 1'b0;
        bus.cdp2mcif_rd_req_pd    = '0;
        bus.mcif2cdp_rd_rsp_ready = 1'b0;
        bus.mem_rd_data           = '0;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        test_reset();
        @(negedge clk);
        rstn = 1'b1;
        test_single_burst();
        test_credit_exhaust();
        test_backpressure();
        test_addr_wrap();
        test_simul_pop();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nv_nvdla_mcif_cdp_rdrsp.md
NV_NVDLA_MCIF_CDP_RDRSP -- requirements
Module: NV_NVDLA_MCIF_cdp_rdrsp

Interface
REQ-001 SHALL have parameter LAT_DEPTH, default 32, giving the CDP-side latency-FIFO depth (credit pool size, 2..255).
REQ-002 SHALL have port nvdla_core_clk  in  1  the single clock.
REQ-003 SHALL have port nvdla_core_rstn  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have port cdp2mcif_rd_req_valid  in  1  read request valid.
REQ-005 SHALL have port cdp2mcif_rd_req_ready  out  1  read request accept.
REQ-006 SHALL have port cdp2mcif_rd_req_pd  in  47  request: [31:0] byte address, [46:32] size = atoms-1.
REQ-007 SHALL have port mcif2cdp_rd_rsp_valid  out  1  response valid.
REQ-008 SHALL have port mcif2cdp_rd_rsp_ready  in  1  response accept.
REQ-009 SHALL have port mcif2cdp_rd_rsp_pd  out  65  response: [63:0] data, [64] mask, always 1.
REQ-010 SHALL have port cdp2mcif_rd_cdt_lat_fifo_pop  in  1  one credit returned per cycle asserted.
REQ-011 SHALL have port mem_rd_en  out  1  backing-store read strobe.
REQ-012 SHALL have port mem_rd_addr  out  32  backing-store byte address; [2:0] always 0.
REQ-013 SHALL have port mem_rd_data  in  64  read data; valid exactly one cycle after mem_rd_en.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, BURST.
REQ-015 In IDLE, req_ready SHALL be 1; in BURST it SHALL be 0.
REQ-016 On valid&ready, SHALL latch addr with [2:0] forced to 0 and remaining = size+1 atoms (16-bit counter), then enter BURST next cycle.
REQ-017 In BURST, SHALL assert mem_rd_en for one atom in a cycle only if credit>0 and (output-buffer occupancy + reads in flight) < 2.
REQ-018 Each issued atom SHALL advance the address by 8 modulo 2^32 (wrap from 0xFFFFFFF8 to 0) and decrement remaining.
REQ-019 The cycle issuing the last atom SHALL return the FSM to IDLE; a new request MAY be accepted the following cycle while earlier data drains.
REQ-020 Returned mem_rd_data SHALL enter a 2-entry in-order output FIFO; its head drives rsp_pd, and a non-empty FIFO drives rsp_valid.
REQ-021 Once asserted, rsp_valid and rsp_pd SHALL hold stable until rsp_ready.
REQ-022 Output data order SHALL equal issue order; no atom SHALL be dropped or duplicated under any rsp_ready pattern.
REQ-023 The credit counter SHALL decrement by 1 per issued atom and increment by 1 per lat_fifo_pop; when both occur in one cycle it SHALL stay unchanged.
REQ-024 A pop with credit already at LAT_DEPTH SHALL leave credit at LAT_DEPTH and raise a sim-only error.
REQ-025 When credit is 0, issue SHALL stall; req_ready SHALL still follow FSM state only.
REQ-026 Latency from mem_rd_en to rsp_valid SHALL be 2 cycles when the output FIFO is empty.
REQ-027 Sustained throughput SHALL be 1 atom/cycle when rsp_ready=1 and credit>0.
REQ-028 A request with size=0 SHALL produce exactly 1 atom; size=0x7FFF SHALL produce 32768 atoms.

Reset
REQ-029 Under reset, state SHALL be IDLE, credit=LAT_DEPTH, the output FIFO SHALL be empty, and no read SHALL be in flight.
REQ-030 Under reset, req_ready=1, rsp_valid=0, mem_rd_en=0, mem_rd_addr=0, and rsp_pd=0.
REQ-031 Reset asserted mid-burst SHALL discard the burst, any in-flight read, and buffered data immediately; no response SHALL follow deassertion.

Verification
REQ-032 Single request addr=0x1000, size=3, rsp_ready=1 -> mem_rd_addr 0x1000,0x1008,0x1010,0x1018 on consecutive cycles; 4 responses in order, mask=1.
REQ-033 Credit exhaustion: LAT_DEPTH=4, no pops, size=7 -> exactly 4 atoms issued, then stall; one pop -> exactly one more atom issued.
REQ-034 Backpressure: size=5, rsp_ready toggled randomly -> 6 atoms delivered in order, pd stable while valid&!ready, at most 2 reads outstanding plus buffered.
REQ-035 Address wrap: addr=0xFFFFFFF8, size=1 -> reads at 0xFFFFFFF8 then 0x00000000.
REQ-036 Simultaneous issue and pop at credit=LAT_DEPTH-1 -> credit unchanged; pop at full credit -> credit stays LAT_DEPTH and error flagged.
REQ-037 Reset after 2 of 8 atoms issued -> after release: req_ready=1, rsp_valid=0, credit=LAT_DEPTH, and no stale data returned.
